btn_mode_router: RTL and testbench
==================================

// Module: btn_mode_router
// PURPOSE
//  Parametrised button front end: per-button 2FF sync and debounce, press-edge pulse, auto-repeat on long hold,
//  and routing of each button to exactly one of NUM_MODE consumer modes (watch, stopwatch, ...).
//  Sits between the raw board buttons and the mode FSMs.
//  Buttons held across a mode change are locked until released, so a press never leaks into the new mode.
// PARAMETERS
//  NUM_BTN        4            number of physical buttons
//  NUM_MODE       2            number of consumer modes
//  MODE_W         $clog2(NUM_MODE) (min 1)  width of mode select
//  DB_CYCLES      1_000_000    consecutive stable cycles to accept a level change (10 ms @100 MHz)
//  HOLD_CYCLES    50_000_000   cycles after the press pulse before the first repeat pulse
//  REPEAT_CYCLES  10_000_000   cycles between repeat pulses while held
// PORTS
//  clk            in   1                  system clock
//  rst            in   1                  reset, asynchronous, active-low (0 = reset)
//  i_btn          in   NUM_BTN            raw asynchronous buttons, 1 = pressed
//  i_mode         in   MODE_W             mode select, treated as synchronous to clk
//  o_btn_pulse    out  NUM_MODE*NUM_BTN   1-cycle press/repeat pulses; bit [m*NUM_BTN+b] = button b to mode m
//  o_btn_level    out  NUM_MODE*NUM_BTN   debounced held level, same indexing
//  o_mode_onehot  out  NUM_MODE           registered one-hot decode of the active mode
//  o_mode_err     out  1                  registered mode >= NUM_MODE
// BEHAVIOUR
//  - Reset: every output 0; mode register 0; every channel in ARM; all counters 0; debounced level 0.
//  - Sync: i_btn passes through 2 flops; the debouncer sees only the synchronised bit.
//  - Debounce: a counter runs while sync != debounced and clears on any match; at DB_CYCLES-1 the debounced level
//    takes the sync value and the counter clears. Glitches shorter than DB_CYCLES are ignored.
//  - Per-channel FSM, outputs registered:
//    ARM     : entered from reset. Goes to IDLE after sync has been 0 for DB_CYCLES consecutive cycles.
//              A button held through reset release produces nothing until released.
//    IDLE    : on debounced 0->1 -> PRESS, emit one pulse, hold counter cleared.
//    PRESS   : level=1; counter reaches HOLD_CYCLES-1 -> REPEAT, emit a pulse; debounced 0 -> IDLE.
//    REPEAT  : level=1; pulse every REPEAT_CYCLES; debounced 0 -> IDLE.
//    LOCKED  : level=0, no pulses; debounced 0 -> IDLE.
//  - Latency: a clean edge on i_btn at edge 0 gives o_btn_pulse high in cycle DB_CYCLES+3 (2 sync + DB + 1 out reg).
//  - Mode change: the mode register updates when i_mode differs. In that same cycle, every channel in
//    PRESS/REPEAT goes to LOCKED.
//    A debounced press edge in the cycle the mode changes also goes to LOCKED (the mode change wins, no pulse).
//  - Routing: pulse and level for button b appear only on mode slot m = current mode; all other slots are 0.
//    With o_mode_err=1, all pulse and level outputs are 0, channels keep running, and o_mode_onehot=0.
//  - Counters saturate and never wrap; counter widths come from $clog2 of the largest count.
//  - Async reset mid-press: outputs drop to 0 immediately; the channel returns to ARM.
// STRUCTURE
//  - Shared package/header btn_pkg:
//      channel-state encoding (ARM, IDLE, PRESS, REPEAT, LOCKED, 3 bits);
//      clog2 helper; default cycle constants.
//  - Sub-module btn_channel: one button's sync, debounce, counters and FSM.
//      Inputs: clk, rst, i_btn, i_lock. Outputs: o_pulse, o_level.
//      Instantiated NUM_BTN times in a generate loop.
//  - Top level: mode register, change detect (i_lock), one-hot/err decode, routing mux.
// TESTING  (NUM_BTN=4, NUM_MODE=3, DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
//  1. Mode 0, btn0 rises at cycle 0 and holds -> pulse bit0 in cycle 7 only, level bit0 from 7.
//     Repeat pulses at 27, 35, 43. Release -> level 0 after 7 cycles.
//  2. Mode 1, btn2 glitch of 3 cycles -> no pulse, no level. 5-cycle press -> exactly one pulse, on bit 6.
//  3. Mode 0, btn1 held past its pulse; switch i_mode to 1 -> level drops the next cycle.
//     No pulses in mode 0 or mode 1 until released. A re-press gives a pulse on bit 5.
//  4. Debounced press edge in the same cycle as a mode change -> no pulse anywhere; the channel is LOCKED.
//  5. i_mode=3 -> o_mode_err=1, o_mode_onehot=0, all outputs 0.
//     Back to 2 -> o_mode_onehot=3'b100 one cycle later.
//  6. rst low while btn3 held -> outputs 0 at once. Release rst with btn3 still held -> no pulse.
//     Release btn3 for 4+ cycles, then press -> pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button front end (btn_channel, btn_mode_router):
//   - chState_t : per-channel FSM state encoding (3 bits)
//   - DEF_*     : default sizing and timing constants (timing at 100 MHz)
//   - clog2Min1 : counter/select width helper that never returns 0
//   - max3      : largest of three counts, used to size the shared hold counter
// No ports; imported by the other files.
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PRESS  = 3'd2,
    ST_REPEAT = 3'd3,
    ST_LOCKED = 3'd4
  } chState_t;

  localparam int DEF_NUM_BTN       = 4;
  localparam int DEF_NUM_MODE      = 2;
  localparam int DEF_DB_CYCLES     = 1_000_000;   // 10 ms
  localparam int DEF_HOLD_CYCLES   = 50_000_000;  // 500 ms
  localparam int DEF_REPEAT_CYCLES = 10_000_000;  // 100 ms

  // $clog2 gives 0 for 1 and 1 for 2; a zero-width vector is illegal, so
  // clamp to 1 bit.
  function automatic int clog2Min1(input int value);
    return (value > 2) ? $clog2(value) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// One button: 2-flop synchroniser, debouncer, hold/repeat timer and the
// channel FSM. Pulse and level outputs are registered.
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous reset, active low
//   i_btn   in   raw asynchronous button, 1 = pressed
//   i_lock  in   mode is changing this cycle; an active press is locked out
//   o_pulse out  1-cycle pulse on press and on every auto-repeat
//   o_level out  debounced held level (0 while locked or arming)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_ARM    | after reset; wait for DB_CYCLES consecutive released samples
// ST_IDLE   | released, waiting for a debounced press
// ST_PRESS  | pressed, counting towards the first auto-repeat
// ST_REPEAT | pressed, issuing a pulse every REPEAT_CYCLES
// ST_LOCKED | held across a mode change; silent until released
// -----------------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_lock,
  output logic o_pulse,
  output logic o_level
);

  localparam int DB_W    = clog2Min1(DB_CYCLES);
  localparam int CNT_MAX = max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int CNT_W   = clog2Min1(CNT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic syncMeta;
  logic syncBtn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncMeta <= 1'b0;
      syncBtn  <= 1'b0;
    end else begin
      syncMeta <= i_btn;
      syncBtn  <= syncMeta;
    end
  end

  // Debounce: count consecutive disagreeing samples; any agreeing sample
  // restarts the count, so only an uninterrupted run of DB_CYCLES is accepted.
  logic [DB_W-1:0] dbCnt;
  logic            dbLevel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbCnt   <= '0;
      dbLevel <= 1'b0;
    end else if (syncBtn == dbLevel) begin
      dbCnt <= '0;
    end else if (dbCnt == DB_LAST) begin
      dbLevel <= syncBtn;
      dbCnt   <= '0;
    end else begin
      dbCnt <= dbCnt + 1'b1;
    end
  end

  // One counter serves ARM (release run), PRESS (hold delay) and REPEAT
  // (repeat period); it is cleared on every state change and stops at the
  // terminal count, so it never wraps.
  chState_t         state;
  chState_t         stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             pulseNext;
  logic             levelNext;
  logic             pulseReg;
  logic             levelReg;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pulseNext = 1'b0;
    case (state)
      ST_ARM: begin
        // Uses the synchronised bit, not the debounced level, so a button
        // held through reset release cannot be mistaken for a new press.
        if (syncBtn) begin
          cntNext = '0;
        end else if (cnt == ARM_LAST) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (dbLevel) begin
          cntNext = '0;
          // A press landing on a mode change belongs to neither mode.
          if (i_lock) begin
            stateNext = ST_LOCKED;
          end else begin
            stateNext = ST_PRESS;
            pulseNext = 1'b1;
          end
        end
      end
      ST_PRESS: begin
        if (i_lock) begin
          stateNext = ST_LOCKED;
          cntNext   = '0;
        end else if (!dbLevel) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
        end else if (cnt == HOLD_LAST) begin
          stateNext = ST_REPEAT;
          cntNext   = '0;
          pulseNext = 1'b1;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (i_lock) begin
          stateNext = ST_LOCKED;
          cntNext   = '0;
        end else if (!dbLevel) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
        end else if (cnt == REP_LAST) begin
          cntNext   = '0;
          pulseNext = 1'b1;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!dbLevel) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
        end
      end
      default: begin
        stateNext = ST_ARM;
        cntNext   = '0;
      end
    endcase
    levelNext = (stateNext == ST_PRESS) || (stateNext == ST_REPEAT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_ARM;
      cnt      <= '0;
      pulseReg <= 1'b0;
      levelReg <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      pulseReg <= pulseNext;
      levelReg <= levelNext;
    end
  end

  assign o_pulse = pulseReg;
  assign o_level = levelReg;

endmodule

// File: rtl/btn_mode_router.sv
// -----------------------------------------------------------------------------
// btn_mode_router
// Button front end for the mode FSMs: one btn_channel per button, a mode
// register with change detect, registered one-hot/error decode, and routing
// of every button to the slot of the active mode only.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active low
//   i_btn          in   [NUM_BTN]           raw buttons, 1 = pressed
//   i_mode         in   [MODE_W]            mode select, synchronous to clk
//   o_btn_pulse    out  [NUM_MODE*NUM_BTN]  press/repeat pulses, bit m*NUM_BTN+b
//   o_btn_level    out  [NUM_MODE*NUM_BTN]  debounced held level, same indexing
//   o_mode_onehot  out  [NUM_MODE]          registered one-hot of active mode
//   o_mode_err     out                      registered i_mode >= NUM_MODE
// -----------------------------------------------------------------------------
module btn_mode_router
  import btn_pkg::*;
#(
  parameter int NUM_BTN       = DEF_NUM_BTN,
  parameter int NUM_MODE      = DEF_NUM_MODE,
  parameter int MODE_W        = clog2Min1(NUM_MODE),
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BTN-1:0]           i_btn,
  input  logic [MODE_W-1:0]            i_mode,
  output logic [NUM_MODE*NUM_BTN-1:0]  o_btn_pulse,
  output logic [NUM_MODE*NUM_BTN-1:0]  o_btn_level,
  output logic [NUM_MODE-1:0]          o_mode_onehot,
  output logic                         o_mode_err
);

  logic [MODE_W-1:0]   modeReg;
  logic [NUM_MODE-1:0] modeOnehot;
  logic                modeErr;
  logic                modeChange;
  logic [31:0]         modeWide;
  logic                modeErrNext;
  logic [NUM_MODE-1:0] onehotNext;

  // The compare is done at 32 bits so it stays meaningful when NUM_MODE is
  // a power of two and the error case cannot occur.
  assign modeWide    = 32'(i_mode);
  assign modeChange  = (i_mode != modeReg);
  assign modeErrNext = (modeWide >= 32'(NUM_MODE));

  always_comb begin
    onehotNext = '0;
    for (int m = 0; m < NUM_MODE; m++) begin
      if (modeWide == 32'(m)) begin
        onehotNext[m] = 1'b1;
      end
    end
  end

  // Decode is reloaded every cycle (not only on change) so the one-hot comes
  // up one cycle after reset release even if i_mode never moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      modeReg    <= '0;
      modeOnehot <= '0;
      modeErr    <= 1'b0;
    end else begin
      if (modeChange) begin
        modeReg <= i_mode;
      end
      modeOnehot <= onehotNext;
      modeErr    <= modeErrNext;
    end
  end

  logic [NUM_BTN-1:0] chPulse;
  logic [NUM_BTN-1:0] chLevel;

  for (genvar b = 0; b < NUM_BTN; b++) begin : gChan
    btn_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) uChan (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (i_btn[b]),
      .i_lock  (modeChange),
      .o_pulse (chPulse[b]),
      .o_level (chLevel[b])
    );
  end

  // The registered one-hot is all zero on a mode error, so gating with it
  // also blanks every slot while the mode is invalid.
  for (genvar m = 0; m < NUM_MODE; m++) begin : gMode
    for (genvar b = 0; b < NUM_BTN; b++) begin : gBtn
      assign o_btn_pulse[m*NUM_BTN+b] = chPulse[b] & modeOnehot[m];
      assign o_btn_level[m*NUM_BTN+b] = chLevel[b] & modeOnehot[m];
    end
  end

  assign o_mode_onehot = modeOnehot;
  assign o_mode_err    = modeErr;

endmodule

// File: tb/tb_btn_mode_router.sv
`timescale 1ns/1ps
module tb_btn_mode_router;

  localparam int NB   = 4;
  localparam int NM   = 3;
  localparam int MW   = 2;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int NO   = NM * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn = '0;
  logic [MW-1:0] mode = '0;
  logic [NO-1:0] pulse;
  logic [NO-1:0] level;
  logic [NM-1:0] onehot;
  logic          err;

  int nCmp = 0;
  int nBad = 0;

  btn_mode_router #(
    .NUM_BTN       (NB),
    .NUM_MODE      (NM),
    .MODE_W        (MW),
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_btn         (btn),
    .i_mode        (mode),
    .o_btn_pulse   (pulse),
    .o_btn_level   (level),
    .o_mode_onehot (onehot),
    .o_mode_err    (err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. Debounce is expressed as "the seen value has been steady
  // for DB edges"; repeats are computed from the age of the press.
  // ---------------------------------------------------------------------------
  typedef enum int {M_ARMED, M_READY, M_HELD, M_LOCKED} phase_t;

  bit            mS1 [NB];
  bit            mS2 [NB];
  bit            mLast [NB];
  int            mRun [NB];
  bit            mDb [NB];
  phase_t        mPh [NB];
  longint        mPressAt [NB];
  longint        mEdge;
  logic [MW-1:0] mMode;
  bit   [NM-1:0] mOnehot;
  bit            mErr;
  bit   [NB-1:0] mChPulse;
  logic [NO-1:0] expPulse;
  logic [NO-1:0] expLevel;

  always @(posedge clk or negedge rst) begin
    bit     lock;
    bit     sv;
    bit     steady;
    bit     oldDb;
    bit     p;
    longint age;
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        mS1[b] = 1'b0; mS2[b] = 1'b0; mLast[b] = 1'b0; mRun[b] = 0;
        mDb[b] = 1'b0; mPh[b] = M_ARMED; mPressAt[b] = 0;
      end
      mEdge = 0; mMode = '0; mOnehot = '0; mErr = 1'b0; mChPulse = '0;
      expPulse = '0; expLevel = '0;
    end else begin
      mEdge++;
      lock = (mode != mMode);
      for (int b = 0; b < NB; b++) begin
        sv = mS2[b];
        mS2[b] = mS1[b];
        mS1[b] = btn[b];
        if (sv == mLast[b]) begin
          if (mRun[b] < 1000) mRun[b]++;
        end else begin
          mRun[b] = 1;
        end
        mLast[b] = sv;
        steady = (mRun[b] >= DB);
        oldDb = mDb[b];
        p = 1'b0;
        case (mPh[b])
          M_ARMED:  if (!sv && steady) mPh[b] = M_READY;
          M_READY:  if (oldDb) begin
                      if (lock) mPh[b] = M_LOCKED;
                      else begin mPh[b] = M_HELD; mPressAt[b] = mEdge; p = 1'b1; end
                    end
          M_HELD:   if (lock) mPh[b] = M_LOCKED;
                    else if (!oldDb) mPh[b] = M_READY;
                    else begin
                      age = mEdge - mPressAt[b];
                      if (age >= HOLD && ((age - HOLD) % REP) == 0) p = 1'b1;
                    end
          M_LOCKED: if (!oldDb) mPh[b] = M_READY;
          default:  mPh[b] = M_ARMED;
        endcase
        if (steady) mDb[b] = sv;
        mChPulse[b] = p;
      end
      mMode = mode;
      mErr = (int'(mode) >= NM);
      for (int m = 0; m < NM; m++) mOnehot[m] = (int'(mode) == m);
      for (int m = 0; m < NM; m++)
        for (int b = 0; b < NB; b++) begin
          expPulse[m*NB+b] = mChPulse[b] & mOnehot[m];
          expLevel[m*NB+b] = (mPh[b] == M_HELD) & mOnehot[m];
        end
    end
  end

  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    tick();
    check("model_pulse", 64'(pulse), 64'(expPulse));
    check("model_level", 64'(level), 64'(expLevel));
    check("model_onehot", 64'(onehot), 64'(mOnehot));
    check("model_err", 64'(err), 64'(mErr));
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic [MW-1:0] modeIn;
    logic [NM-1:0] expOnehot;
    logic          expErr;
  } modeVec_t;

  modeVec_t modeTab [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NO-1:0] acc;
    logic [NO-1:0] accOther;
    int            cntP;
    int            rate;

    modeTab[0] = '{2'd0, 3'b001, 1'b0};
    modeTab[1] = '{2'd1, 3'b010, 1'b0};
    modeTab[2] = '{2'd2, 3'b100, 1'b0};
    modeTab[3] = '{2'd3, 3'b000, 1'b1};
    modeTab[4] = '{2'd2, 3'b100, 1'b0};
    modeTab[5] = '{2'd3, 3'b000, 1'b1};
    modeTab[6] = '{2'd0, 3'b001, 1'b0};
    modeTab[7] = '{2'd1, 3'b010, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pulse", 64'(pulse), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_onehot", 64'(onehot), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst = 1'b1;
    step();
    check("onehot_after_rst", 64'(onehot), 64'h1);
    stepN(8);

    // 1: press/repeat timing in mode 0
    btn[0] = 1'b1;
    for (int n = 1; n <= 44; n++) begin
      step();
      check("t1_pulse", 64'(pulse),
            (n == 7 || n == 27 || n == 35 || n == 43) ? 64'h1 : 64'h0);
      check("t1_level", 64'(level), (n >= 7) ? 64'h1 : 64'h0);
    end
    btn[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      check("t1_rel_pulse", 64'(pulse), 64'h0);
      check("t1_rel_level", 64'(level), (n < 7) ? 64'h1 : 64'h0);
    end

    // 2: glitch rejection and short press in mode 1
    mode = 2'd1;
    stepN(6);
    btn[2] = 1'b1;
    stepN(3);
    btn[2] = 1'b0;
    acc = '0;
    for (int n = 0; n < 15; n++) begin step(); acc |= pulse | level; end
    check("t2_glitch", 64'(acc), 64'h0);
    btn[2] = 1'b1;
    cntP = 0; accOther = '0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 6) btn[2] = 1'b0;
      step();
      if (pulse[6]) cntP++;
      accOther |= pulse & ~(NO'(1) << 6);
    end
    check("t2_pulse_count", 64'(cntP), 64'd1);
    check("t2_other_bits", 64'(accOther), 64'h0);

    // 3: mode change while held locks the button
    mode = 2'd0;
    stepN(6);
    btn[1] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 7) check("t3_press_pulse", 64'(pulse), 64'h2);
    end
    check("t3_level_before", 64'(level), 64'h2);
    mode = 2'd1;
    step();
    check("t3_level_drop", 64'(level), 64'h0);
    acc = '0;
    for (int n = 0; n < 40; n++) begin step(); acc |= pulse | level; end
    check("t3_locked_quiet", 64'(acc), 64'h0);
    btn[1] = 1'b0;
    stepN(10);
    btn[1] = 1'b1;
    stepN(7);
    check("t3_repress_pulse", 64'(pulse), 64'h20);
    btn[1] = 1'b0;
    stepN(10);

    // 4: debounced press edge coincides with a mode change
    btn[3] = 1'b1;
    stepN(6);
    mode = 2'd2;
    step();
    check("t4_no_pulse", 64'(pulse), 64'h0);
    check("t4_no_level", 64'(level), 64'h0);
    acc = '0;
    for (int n = 0; n < 15; n++) begin step(); acc |= pulse | level; end
    check("t4_locked", 64'(acc), 64'h0);
    btn[3] = 1'b0;
    stepN(10);
    btn[3] = 1'b1;
    stepN(7);
    check("t4_repress_pulse", 64'(pulse), 64'h800);
    btn[3] = 1'b0;
    stepN(10);

    // 5: mode decode table
    foreach (modeTab[i]) begin
      mode = modeTab[i].modeIn;
      step();
      check("t5_onehot", 64'(onehot), 64'(modeTab[i].expOnehot));
      check("t5_err", 64'(err), 64'(modeTab[i].expErr));
    end
    mode = 2'd3;
    stepN(2);
    btn[0] = 1'b1;
    acc = '0;
    for (int n = 0; n < 12; n++) begin step(); acc |= pulse | level; end
    check("t5_err_blank", 64'(acc), 64'h0);
    mode = 2'd0;
    btn[0] = 1'b0;
    stepN(12);

    // 6: async reset while held
    btn[3] = 1'b1;
    stepN(10);
    check("t6_level_held", 64'(level), 64'h8);
    rst = 1'b0;
    #1;
    check("t6_rst_pulse", 64'(pulse), 64'h0);
    check("t6_rst_level", 64'(level), 64'h0);
    check("t6_rst_onehot", 64'(onehot), 64'h0);
    stepN(2);
    rst = 1'b1;
    acc = '0;
    for (int n = 0; n < 30; n++) begin step(); acc |= pulse | level; end
    check("t6_held_through_rst", 64'(acc), 64'h0);
    btn[3] = 1'b0;
    stepN(6);
    btn[3] = 1'b1;
    stepN(7);
    check("t6_press_after_arm", 64'(pulse), 64'h8);
    btn[3] = 1'b0;
    stepN(10);

    // randomized traffic against the model
    rate = 15;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 3;
          1: rate = 15;
          default: rate = 60;
        endcase
      end
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, rate) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 80) == 0) mode = MW'($urandom_range(0, 3));
      if (n == 1500) begin
        rst = 1'b0;
        #1;
        check("rand_async_rst", 64'({pulse, level}), 64'h0);
        stepN(2);
        rst = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
